melay_seq_101_ov: RTL and testbench

- Mealy-type serial pattern detector for the bit sequence "101", with overlapping detection.
- Samples one serial input bit per clock.
- Asserts a detect flag in the same cycle that the final '1' of a "101" pattern is present on the input.
- Leaf block for serial-stream monitors. It has no handshake; one input bit is consumed every clock.

---
 rtl/melay_seq_101_pkg.sv | 12 +
 rtl/melay_seq_101_ov.sv | 51 +++++
 tb/tb_melay_seq_101_ov.sv | 119 +++++++++++
 3 files changed

// File: rtl/melay_seq_101_pkg.sv
// Shared state encoding and pattern constant for the "101" overlapping Mealy detector.
package melay_seq_101_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_1    = 2'b01,
        S_10   = 2'b10
    } state_e;

    localparam logic [2:0] PATTERN = 3'b101;

endpackage

// File: rtl/melay_seq_101_ov.sv
// Mealy "101" detector with overlap; one serial bit consumed per clock.
// Optional macro DET_REG_EN registers det_out (one cycle later, glitch-free).
module melay_seq_101_ov
    import melay_seq_101_pkg::*;
(
    input  logic in_seq,
    input  logic clk,
    input  logic rst,
    output logic det_out
);

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_1    = S_1;
    localparam logic [1:0] ST_10   = S_10;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       w_hit;

    // The final pattern bit arriving while "10" is held completes a match.
    assign w_hit = (r_state == ST_10) && (in_seq == PATTERN[0]);

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next = in_seq ? ST_1 : ST_IDLE;
            ST_1:    w_next = in_seq ? ST_1 : ST_10;
            ST_10:   w_next = in_seq ? ST_1 : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

`ifdef DET_REG_EN
    logic r_det;

    always_ff @(posedge clk) begin
        if (rst) r_det <= 1'b0;
        else     r_det <= w_hit;
    end

    assign det_out = r_det;
`else
    assign det_out = w_hit & ~rst;
`endif

endmodule

// File: tb/tb_melay_seq_101_ov.sv
// Scoreboard bench for melay_seq_101_ov: directed test-plan sequences then random bits.
module tb_melay_seq_101_ov;

    typedef struct {
        int id;
        bit exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_seq = 1'b0;
    logic det_out;

    int total = 0;
    int bad = 0;
    int step_id = 0;

    sb_t sb[$];
    bit  hist[$];      // bits seen since the last reset, most recent last
    bit  prev_reg = 1'b0;

    melay_seq_101_ov dut (
        .in_seq (in_seq),
        .clk    (clk),
        .rst    (rst),
        .det_out(det_out)
    );

    always #5 clk = ~clk;

    // Reference: a detection is "the last three bits since reset read 1,0,1".
    function automatic bit last3_is_101(bit b);
        int n;
        n = hist.size();
        if (n < 2) return 1'b0;
        return (hist[n-2] == 1'b1) && (hist[n-1] == 1'b0) && b;
    endfunction

    task automatic step(input bit b, input bit r);
        sb_t e;
        bit  m;
        @(posedge clk);
        #1;
        rst = r;
        in_seq = b;
        m = r ? 1'b0 : last3_is_101(b);
        e.id = step_id;
`ifdef DET_REG_EN
        e.exp = prev_reg;
        prev_reg = m;
`else
        e.exp = m;
`endif
        sb.push_back(e);
        step_id++;
        if (r) begin
            hist.delete();
        end else begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    task automatic run_seq(input bit bits[]);
        foreach (bits[i]) step(bits[i], 1'b0);
    endtask

    // Monitor: each negedge presents one output sample for the oldest pending step.
    always @(negedge clk) begin
        sb_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (det_out !== e.exp) begin
                bad++;
                $display("FAIL det_out step=%0d got=%b exp=%b", e.id, det_out, e.exp);
            end
        end
    end

    initial begin
        // reset held two clocks with in_seq=1
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        // basic match
        run_seq('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        // overlap
        run_seq('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        // non-match
        run_seq('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        // prefix reuse
        run_seq('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        // reset mid-pattern
        run_seq('{1'b1, 1'b0});
        step(1'b0, 1'b1);
        run_seq('{1'b1, 1'b0, 1'b0});
        // reset while a match would complete
        run_seq('{1'b1, 1'b0});
        step(1'b1, 1'b1);
        run_seq('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        // random stream with occasional resets
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
